gp_carry_resolve: RTL and testbench

- Consumer end of the per-bit generate/propagate/half-sum interface produced by the single-bit g/h/p cells of the 6-bit adder.
- Takes WIDTH-bit vectors g, p, h plus a carry-in, resolves carries with two-level lookahead and emits sum and carry-out.
- Two-stage registered pipeline with valid/ready handshakes on both sides. Sits between the g/h/p cell array and the adder result register.

---
 rtl/gp_adder_pkg.sv | 24 ++
 rtl/gp_group_lookahead.sv | 43 ++++
 rtl/gp_carry_resolve.sv | 174 +++++++++++++++++
 tb/tb_gp_carry_resolve.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gp_adder_pkg.sv
// ----------------------------------------------------------------------------
// gp_adder_pkg
// Shared types for the g/h/p adder slice.
//   GP_WIDTH    : default operand width of the adder (6 bits)
//   gph_vec_t   : per-bit generate / propagate / half-sum vectors
//   result_t    : resolved adder result {sum, cout}
// Optional build macro used by the slice: GP_OVF_EN (adds overflow output).
// ----------------------------------------------------------------------------
package gp_adder_pkg;

    localparam int GP_WIDTH = 6;

    typedef struct packed {
        logic [GP_WIDTH-1:0] g;
        logic [GP_WIDTH-1:0] p;
        logic [GP_WIDTH-1:0] h;
    } gph_vec_t;

    typedef struct packed {
        logic [GP_WIDTH-1:0] sum;
        logic                cout;
    } result_t;

endpackage

// File: rtl/gp_group_lookahead.sv
// ----------------------------------------------------------------------------
// gp_group_lookahead
// Combinational group lookahead over a W-bit slice of g/p vectors.
// Ports:
//   g, p     in  [W-1:0]  per-bit generate / propagate of the group
//   c_in     in  1        carry into the lowest bit of the group
//   gg       out 1        group carry-out assuming carry-in 0
//   gp       out 1        group carry-out assuming carry-in 1
//   carries  out [W-1:0]  carries[i] = carry out of bit i given c_in
// Build macro: none (GP_OVF_EN affects only the top level).
// ----------------------------------------------------------------------------
module gp_group_lookahead #(
    parameter int W = 3
) (
    input  logic [W-1:0] g,
    input  logic [W-1:0] p,
    input  logic         c_in,
    output logic         gg,
    output logic         gp,
    output logic [W-1:0] carries
);

    logic c_zero;
    logic c_one;
    logic c_run;

    // Three carry chains evaluated side by side: forced 0, forced 1, real c_in.
    always_comb begin
        c_zero  = 1'b0;
        c_one   = 1'b1;
        c_run   = c_in;
        carries = '0;
        for (int i = 0; i < W; i++) begin
            c_zero     = g[i] | (p[i] & c_zero);
            c_one      = g[i] | (p[i] & c_one);
            c_run      = g[i] | (p[i] & c_run);
            carries[i] = c_run;
        end
        gg = c_zero;
        gp = c_one;
    end

endmodule

// File: rtl/gp_carry_resolve.sv
// ----------------------------------------------------------------------------
// gp_carry_resolve
// Two-stage pipelined carry resolver for per-bit g/p/h vectors.
// Stage 1 resolves the low-group carries and the high-group carry-out for
// both possible carry-ins; stage 2 selects with c[LO_W] and forms the sum.
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   in_valid, in_ready    input handshake
//   g, p, h  [WIDTH-1:0]  per-bit generate, inclusive propagate, half-sum
//   cin                   carry into bit 0
//   out_valid, out_ready  output handshake
//   sum      [WIDTH-1:0]  resolved sum (registered)
//   cout                  carry out of bit WIDTH-1 (registered)
//   ovf                   two's-complement overflow, only with GP_OVF_EN
// Build macro: GP_OVF_EN adds the ovf output and its stage-2 register.
// ----------------------------------------------------------------------------
module gp_carry_resolve
    import gp_adder_pkg::*;
#(
    parameter int WIDTH = GP_WIDTH,
    parameter int LO_W  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] h,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef GP_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int HI_W = WIDTH - LO_W;

    logic adv1;
    logic adv2;

    // Stage-1 combinational results
    logic            lo_gg;
    logic            lo_gp;
    logic [LO_W-1:0] lo_carries;
    logic            hi_gg;
    logic            hi_gp;
    logic [HI_W-1:0] hi1_carries;

    // Stage-1 registers
    logic             vld_p1;
    logic [WIDTH-1:0] h_p1;
    logic             cin_p1;
    logic [LO_W-1:0]  c_lo_p1;
    logic             gg_p1;
    logic             gp_p1;
    logic [HI_W-1:0]  g_hi_p1;
    logic [HI_W-1:0]  p_hi_p1;

    // Stage-2 combinational results
    logic             hi2_gg;
    logic             hi2_gp;
    logic [HI_W-1:0]  hi2_carries;
    logic [WIDTH:0]   c_all;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    // Stage-2 registers
    logic             vld_p2;
    logic [WIDTH-1:0] sum_p2;
    logic             cout_p2;

    logic unused_bits;

    assign adv2     = !vld_p2 | out_ready;
    assign adv1     = !vld_p1 | adv2;
    assign in_ready = adv1;

    gp_group_lookahead #(.W(LO_W)) u_lo (
        .g       (g[LO_W-1:0]),
        .p       (p[LO_W-1:0]),
        .c_in    (cin),
        .gg      (lo_gg),
        .gp      (lo_gp),
        .carries (lo_carries)
    );

    // High group is evaluated without its real carry-in; stage 2 picks gg/gp.
    gp_group_lookahead #(.W(HI_W)) u_hi (
        .g       (g[WIDTH-1:LO_W]),
        .p       (p[WIDTH-1:LO_W]),
        .c_in    (1'b0),
        .gg      (hi_gg),
        .gp      (hi_gp),
        .carries (hi1_carries)
    );

    // ---- stage 1 boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            h_p1    <= '0;
            cin_p1  <= 1'b0;
            c_lo_p1 <= '0;
            gg_p1   <= 1'b0;
            gp_p1   <= 1'b0;
            g_hi_p1 <= '0;
            p_hi_p1 <= '0;
        end else if (adv1) begin
            vld_p1  <= in_valid;
            h_p1    <= h;
            cin_p1  <= cin;
            c_lo_p1 <= lo_carries;
            gg_p1   <= hi_gg;
            gp_p1   <= hi_gp;
            g_hi_p1 <= g[WIDTH-1:LO_W];
            p_hi_p1 <= p[WIDTH-1:LO_W];
        end
    end

    // Internal high-group carries, now that c[LO_W] is known.
    gp_group_lookahead #(.W(HI_W)) u_hi_int (
        .g       (g_hi_p1),
        .p       (p_hi_p1),
        .c_in    (c_lo_p1[LO_W-1]),
        .gg      (hi2_gg),
        .gp      (hi2_gp),
        .carries (hi2_carries)
    );

    // c_all[i] is the carry into bit i; c_all[WIDTH] is the carry-out.
    assign c_all  = {hi2_carries, c_lo_p1, cin_p1};
    assign sum_d  = h_p1 ^ c_all[WIDTH-1:0];
    assign cout_d = c_lo_p1[LO_W-1] ? gp_p1 : gg_p1;

    // ---- stage 2 boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            sum_p2  <= '0;
            cout_p2 <= 1'b0;
        end else if (adv2) begin
            vld_p2  <= vld_p1;
            sum_p2  <= sum_d;
            cout_p2 <= cout_d;
        end
    end

`ifdef GP_OVF_EN
    logic ovf_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_p2 <= 1'b0;
        end else if (adv2) begin
            ovf_p2 <= c_all[WIDTH] ^ c_all[WIDTH-1];
        end
    end

    assign ovf = ovf_p2;
`endif

    assign out_valid = vld_p2;
    assign sum       = sum_p2;
    assign cout      = cout_p2;

    // Lookahead outputs that this configuration does not consume.
    assign unused_bits = ^{lo_gg, lo_gp, hi1_carries, hi2_gg, hi2_gp, c_all[WIDTH]};

endmodule

// File: tb/tb_gp_carry_resolve.sv
module tb_gp_carry_resolve;
    import gp_adder_pkg::*;

    localparam int W = GP_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] g = '0;
    logic [W-1:0] p = '0;
    logic [W-1:0] h = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
`ifdef GP_OVF_EN
    logic         ovf;
`endif

    gp_carry_resolve #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g         (g),
        .p         (p),
        .h         (h),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef GP_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        result_t res;
        logic    ovf;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    function automatic gph_vec_t ops(input logic [W-1:0] x, input logic [W-1:0] y);
        gph_vec_t v;
        v.g = x & y;
        v.p = x | y;
        v.h = x ^ y;
        return v;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ov);
        exp_t e;
        e.res.sum  = s;
        e.res.cout = co;
        e.ovf      = ov;
        return e;
    endfunction

    // Arithmetic reference: x + y + cin, overflow from carries into/out of the MSB.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0]   tot;
        logic [W-1:0] low;
        tot = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        low = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, ci};
        return mk(tot[W-1:0], tot[W], tot[W] ^ low[W-1]);
    endfunction

    task automatic check_out(input exp_t f, input string tag);
        chk({tag, "_sum"}, {26'd0, sum}, {26'd0, f.res.sum});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, f.res.cout});
`ifdef GP_OVF_EN
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, f.ovf});
`endif
    endtask

    // One clock: drive, sample at negedge, scoreboard, advance to posedge+1.
    task automatic step(input logic iv, input gph_vec_t v, input logic ci, input logic ordy,
                        input exp_t e, output logic took);
        exp_t f;
        in_valid  = iv;
        g         = v.g;
        p         = v.p;
        h         = v.h;
        cin       = ci;
        out_ready = ordy;
        @(negedge clk);
        took = in_valid && in_ready;
        if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("spurious_out", {31'd0, out_valid}, 32'd0);
            end else if (out_ready) begin
                f = sbq.pop_front();
                check_out(f, "result");
            end else begin
                check_out(sbq[0], "hold");
            end
        end
        if (took) sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        logic t;
        for (int i = 0; i < 20 && sbq.size() > 0; i++) step(1'b0, '0, 1'b0, 1'b1, '0, t);
        chk({tag, "_drain"}, sbq.size(), 32'd0);
    endtask

    initial begin
        logic         took;
        logic [W-1:0] x, y;
        logic         ci;
        int           sent;
        gph_vec_t     nv;

        // Reset state
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {26'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First transfer and two-cycle latency: 21 + 13
        step(1'b1, ops(6'd21, 6'd13), 1'b0, 1'b1, mk(6'd34, 1'b0, 1'b1), took);
        chk("first_accept", {31'd0, took}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        drain("first");

        // Directed stream, out_ready high: one accept per cycle
        step(1'b1, ops(6'd63, 6'd1), 1'b0, 1'b1, mk(6'd0, 1'b1, 1'b0), took);
        chk("tp_acc0", {31'd0, took}, 32'd1);
        step(1'b1, ops(6'd63, 6'd1), 1'b1, 1'b1, mk(6'd1, 1'b1, 1'b0), took);
        chk("tp_acc1", {31'd0, took}, 32'd1);
        step(1'b1, ops(6'd31, 6'd1), 1'b0, 1'b1, mk(6'd32, 1'b0, 1'b1), took);
        chk("tp_acc2", {31'd0, took}, 32'd1);
        step(1'b1, ops(6'd0, 6'd0), 1'b0, 1'b1, mk(6'd0, 1'b0, 1'b0), took);
        chk("tp_acc3", {31'd0, took}, 32'd1);
        // Non-adder combinations follow the carry formula literally
        step(1'b1, '{g: 6'd1, p: 6'd0, h: 6'd0}, 1'b0, 1'b1, mk(6'd2, 1'b0, 1'b0), took);
        chk("tp_acc4", {31'd0, took}, 32'd1);
        step(1'b1, '{g: 6'b100000, p: 6'd0, h: 6'd0}, 1'b1, 1'b1, mk(6'd1, 1'b1, 1'b1), took);
        chk("tp_acc5", {31'd0, took}, 32'd1);
        drain("directed");

        // Backpressure: two buffered, third refused, first result held
        step(1'b1, ops(6'd5, 6'd7), 1'b0, 1'b0, model(6'd5, 6'd7, 1'b0), took);
        chk("bp_acc0", {31'd0, took}, 32'd1);
        step(1'b1, ops(6'd40, 6'd30), 1'b1, 1'b0, model(6'd40, 6'd30, 1'b1), took);
        chk("bp_acc1", {31'd0, took}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, ops(6'd17, 6'd50), 1'b0, 1'b0, model(6'd17, 6'd50, 1'b0), took);
            chk("bp_full_refuse", {31'd0, took}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        took = 1'b0;
        for (int i = 0; i < 10 && !took; i++)
            step(1'b1, ops(6'd17, 6'd50), 1'b0, 1'b1, model(6'd17, 6'd50, 1'b0), took);
        chk("bp_third_acc", {31'd0, took}, 32'd1);
        chk("bp_queue_depth", sbq.size(), 32'd2);
        drain("backpressure");

        // Random stream with random out_ready
        sent = 0;
        x = 6'($urandom);
        y = 6'($urandom);
        ci = 1'($urandom);
        for (int cyc = 0; cyc < 3000 && sent < 64; cyc++) begin
            nv = ops(x, y);
            step(1'b1, nv, ci, 1'($urandom_range(0, 1)), model(x, y, ci), took);
            if (took) begin
                sent++;
                x = 6'($urandom);
                y = 6'($urandom);
                ci = 1'($urandom);
            end
        end
        chk("rand_sent", sent, 32'd64);
        drain("random");

        // Asynchronous reset with both stages full
        step(1'b1, ops(6'd9, 6'd9), 1'b0, 1'b0, model(6'd9, 6'd9, 1'b0), took);
        step(1'b1, ops(6'd60, 6'd3), 1'b1, 1'b0, model(6'd60, 6'd3, 1'b1), took);
        chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_sum", {26'd0, sum}, 32'd0);
        chk("arst_cout", {31'd0, cout}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, '0, took);
            chk("no_stale", {31'd0, out_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
